// File: rtl/decoder_4to16.sv
// Registered 4-to-16 line decoder with enable and selectable output polarity.
// Per-line compare lives in a small leaf instantiated once per output bit.

module decoder_4to16_line #(
  parameter int unsigned IDX = 0
) (
  input  logic       enable,
  input  logic [3:0] in4,
  output logic       d_o
);
  localparam logic [3:0] CODE = IDX[3:0];

  assign d_o = enable && (in4 == CODE);
endmodule

module decoder_4to16 #(
  parameter int OUT_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  in4,
  output logic [15:0] out16,
  output logic        out_valid
);
  localparam int unsigned NUM_LINES = 16;
  localparam bit          ACT_LOW   = (OUT_ACTIVE_LOW != 0);
  localparam logic [15:0] IDLE      = ACT_LOW ? 16'hFFFF : 16'h0000;

  logic [NUM_LINES-1:0] d;
  logic [15:0]          out16_d, out16_q;
  logic                 out_valid_q;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    decoder_4to16_line #(.IDX(i)) u_line (
      .enable (enable),
      .in4    (in4),
      .d_o    (d[i])
    );
  end

  always_comb begin
    out16_d = ACT_LOW ? ~d : d;
  end

  // Everything is registered so consumers never see decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      out16_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      out16_q     <= out16_d;
      out_valid_q <= enable;
    end
  end

  assign out16     = out16_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_decoder_4to16.sv
// Bench for decoder_4to16: both polarities driven in parallel, directed cases
// followed by random traffic against an arithmetic reference model.

module tb_decoder_4to16;
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [3:0]  in4;
  logic [15:0] out_hi, out_lo;
  logic        vld_hi, vld_lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_4to16 #(.OUT_ACTIVE_LOW(0)) u_dut_hi (
    .clk(clk), .rst(rst), .enable(enable), .in4(in4),
    .out16(out_hi), .out_valid(vld_hi)
  );

  decoder_4to16 #(.OUT_ACTIVE_LOW(1)) u_dut_lo (
    .clk(clk), .rst(rst), .enable(enable), .in4(in4),
    .out16(out_lo), .out_valid(vld_lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the selected line as a power of two, nothing when disabled or in reset.
  function automatic logic [15:0] ref_hi(input logic r, input logic en, input logic [3:0] code);
    int v;
    v = (r || !en) ? 0 : (1 << int'(code));
    return v[15:0];
  endfunction

  // Apply inputs away from the edge, clock once, then check both DUTs.
  task automatic step(input string tag, input logic r, input logic en, input logic [3:0] code);
    logic [15:0] e;
    @(negedge clk);
    rst = r; enable = en; in4 = code;
    @(posedge clk);
    #1;
    e = ref_hi(r, en, code);
    chk({tag, ".hi"},   {16'h0, out_hi}, {16'h0, e});
    chk({tag, ".lo"},   {16'h0, out_lo}, {16'h0, ~e});
    chk({tag, ".vld"},  {31'h0, vld_hi}, {31'h0, !r && en});
    chk({tag, ".vldl"}, {31'h0, vld_lo}, {31'h0, !r && en});
    if (!r && en) chk({tag, ".ones"}, $countones(out_hi), 1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; in4 = 4'hF;

    // Reset with enable asserted, then release.
    step("rst0", 1'b1, 1'b1, 4'hF);
    step("rst1", 1'b1, 1'b1, 4'hF);
    step("rel",  1'b0, 1'b1, 4'hF);

    // Full sweep high to low.
    for (int c = 15; c >= 0; c--) step($sformatf("sweep%0d", c), 1'b0, 1'b1, 4'(c));

    // Disable, ignore code, re-enable.
    step("dis_b", 1'b0, 1'b0, 4'hB);
    step("dis_3", 1'b0, 1'b0, 4'h3);
    step("ren_a", 1'b0, 1'b1, 4'hA);

    // Reset mid-operation and recovery.
    step("st5a",  1'b0, 1'b1, 4'h5);
    step("st5b",  1'b0, 1'b1, 4'h5);
    step("rmid",  1'b1, 1'b1, 4'h5);
    step("rrec",  1'b0, 1'b1, 4'h5);

    // Active-low spot checks via the paired instance.
    step("lo_2",  1'b0, 1'b1, 4'h2);
    chk("lo_2.abs", {16'h0, out_lo}, 32'h0000_FFFB);
    step("lo_dis", 1'b0, 1'b0, 4'h2);
    chk("lo_dis.abs", {16'h0, out_lo}, 32'h0000_FFFF);

    // Latency: output must not move until the edge that samples the new code.
    step("lat0", 1'b0, 1'b1, 4'h0);
    @(negedge clk);
    in4 = 4'h9;
    #2;
    chk("lat.pre",  {16'h0, out_hi}, 32'h0000_0001);
    @(posedge clk);
    #1;
    chk("lat.post", {16'h0, out_hi}, 32'h0000_0200);

    // Random traffic including simultaneous enable/code changes and sporadic reset.
    for (int k = 0; k < 300; k++) begin
      step($sformatf("rnd%0d", k), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
